issue_select_ctrl: RTL

// Slot allocator and age-ordered issue selector for an NUM_ISSUE_SLOTS-entry issue queue.

---
 rtl/iq_pkg.sv | 25 ++
 rtl/iq_age_matrix.sv | 71 +++++++
 rtl/issue_select_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/iq_pkg.sv
// Shared defaults, index/vector types and a population-count helper for the issue queue.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package iq_pkg;

    localparam int IQ_SLOTS     = 8;
    localparam int IQ_DISPATCH  = 2;
    localparam int IQ_ISSUE     = 2;
    localparam int IQ_IDXW      = $clog2(IQ_SLOTS);
    // widest vector popcount accepts; callers zero-extend into this width
    localparam int IQ_MAX_SLOTS = 32;

    typedef logic [IQ_IDXW-1:0]  slot_idx_t;
    typedef logic [IQ_SLOTS-1:0] slot_vec_t;

    function automatic int popcount(input logic [IQ_MAX_SLOTS-1:0] v);
        int n;
        n = 0;
        for (int i = 0; i < IQ_MAX_SLOTS; i++) begin
            if (v[i]) n = n + 1;
        end
        return n;
    endfunction

endpackage

// File: rtl/iq_age_matrix.sv
// N x N relative-age register: age_q[i][j]=1 means slot i is older than slot j; yields per-slot count of older eligible slots.
// Latency: age update lands at the next edge; older_cnt is combinational from the registered matrix.
// Backpressure: none; the owner only allocates free slots and only reads rows/columns of occupied slots.
module iq_age_matrix import iq_pkg::*; #(
    parameter int N  = IQ_SLOTS,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N-1:0]          occ,
    input  logic [N-1:0]          keep,
    input  logic [N-1:0]          alloc,
    input  logic [N-1:0]          elig,
    output logic [N-1:0][CW-1:0]  older_cnt
);

    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    logic [N-1:0][N-1:0] age_q;
    logic [N-1:0][N-1:0] age_d;
    logic                antisym_ok;

    // A new slot is younger than every surviving slot and every slot taken by a lower lane this cycle
    // (lower lanes always land in lower indices, so r < c identifies them). Its own row is cleared.
    always_comb begin
        age_d = age_q;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r == c) begin
                    age_d[r][c] = 1'b0;
                end else if (alloc[c]) begin
                    age_d[r][c] = keep[r] | (alloc[r] & (r < c));
                end else if (alloc[r]) begin
                    age_d[r][c] = 1'b0;
                end
            end
        end
    end

    // Age register
    always_ff @(posedge clk) begin
        if (reset) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // Column count: how many eligible slots are older than slot i
    always_comb begin
        older_cnt = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (elig[j] && age_q[j][i]) older_cnt[i] = older_cnt[i] + CNT_ONE;
            end
        end
    end

    // Every occupied pair must be ordered in exactly one direction
    always_comb begin
        antisym_ok = 1'b1;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (r != c && occ[r] && occ[c] && (age_q[r][c] == age_q[c][r])) antisym_ok = 1'b0;
            end
        end
    end

    a_age_antisym: assert property (@(posedge clk) disable iff (reset) antisym_ok);

endmodule

// File: rtl/issue_select_ctrl.sv
// Issue-queue slot allocator plus oldest-first selector granting up to ISSUE_WIDTH ready slots per cycle.
// Latency: grants are combinational from requests; a dispatched uop is grantable one cycle after allocation.
// Backpressure: dispatch_ready drops unless DISPATCH_WIDTH slots are free in registered occupancy; no partial accept.
module issue_select_ctrl import iq_pkg::*; #(
    parameter int NUM_ISSUE_SLOTS = IQ_SLOTS,
    parameter int DISPATCH_WIDTH  = IQ_DISPATCH,
    parameter int ISSUE_WIDTH     = IQ_ISSUE,
    parameter int IDXW            = $clog2(NUM_ISSUE_SLOTS)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  flush_pipelines,
    input  logic [DISPATCH_WIDTH-1:0]             dispatch_valid,
    output logic                                  dispatch_ready,
    output logic [DISPATCH_WIDTH-1:0]             alloc_valid,
    output logic [DISPATCH_WIDTH-1:0][IDXW-1:0]   alloc_idx,
    output logic [NUM_ISSUE_SLOTS-1:0]            slot_alloc,
    input  logic [NUM_ISSUE_SLOTS-1:0]            slot_request,
    input  logic [NUM_ISSUE_SLOTS-1:0]            slot_kill,
    output logic [NUM_ISSUE_SLOTS-1:0]            slot_occupied,
    output logic [ISSUE_WIDTH-1:0]                issue_valid,
    output logic [ISSUE_WIDTH-1:0][IDXW-1:0]      issue_idx,
    output logic [NUM_ISSUE_SLOTS-1:0]            slot_grant
);

    localparam int N  = NUM_ISSUE_SLOTS;
    localparam int CW = $clog2(NUM_ISSUE_SLOTS + 1);

    logic [N-1:0]            occ_q;
    logic [N-1:0]            occ_keep;
    logic [N-1:0]            elig;
    logic [N-1:0]            avail;
    logic                    found;
    logic [N-1:0][CW-1:0]    older_cnt;
    logic [IQ_MAX_SLOTS-1:0] free_ext;
    int                      grant_cnt;
    int                      port_cnt;

    // Ready looks only at registered occupancy, so slots freed this cycle are reused next cycle
    always_comb begin
        free_ext        = '0;
        free_ext[N-1:0] = ~occ_q;
        dispatch_ready  = !reset && !flush_pipelines && (popcount(free_ext) >= DISPATCH_WIDTH);
    end

    // Steer accepted lanes to free slots: lowest valid lane takes the lowest free index
    always_comb begin
        avail       = ~occ_q;
        found       = 1'b0;
        alloc_valid = '0;
        alloc_idx   = '0;
        slot_alloc  = '0;
        for (int d = 0; d < DISPATCH_WIDTH; d++) begin
            found = 1'b0;
            if (dispatch_ready && dispatch_valid[d]) begin
                for (int i = 0; i < N; i++) begin
                    if (!found && avail[i]) begin
                        found          = 1'b1;
                        avail[i]       = 1'b0;
                        slot_alloc[i]  = 1'b1;
                        alloc_valid[d] = 1'b1;
                        alloc_idx[d]   = i[IDXW-1:0];
                    end
                end
            end
        end
    end

    // Requests count only on occupied, unkilled slots outside flush/reset
    assign elig     = (reset || flush_pipelines) ? '0 : (occ_q & slot_request & ~slot_kill);
    assign occ_keep = occ_q & ~slot_grant & ~slot_kill;

    // Port p takes the eligible slot with exactly p older eligible slots
    always_comb begin
        issue_valid = '0;
        issue_idx   = '0;
        slot_grant  = '0;
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            for (int i = 0; i < N; i++) begin
                if (elig[i] && (int'(older_cnt[i]) == p)) begin
                    issue_valid[p] = 1'b1;
                    issue_idx[p]   = i[IDXW-1:0];
                    slot_grant[i]  = 1'b1;
                end
            end
        end
    end

    // Occupancy: grants and kills free at the edge, new allocations fill; flush empties the queue
    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q <= '0;
        end else if (flush_pipelines) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_keep | slot_alloc;
        end
    end

    assign slot_occupied = reset ? '0 : occ_q;

    iq_age_matrix #(
        .N  (N),
        .CW (CW)
    ) u_age (
        .clk       (clk),
        .reset     (reset),
        .occ       (occ_q),
        .keep      (occ_keep),
        .alloc     (slot_alloc),
        .elig      (elig),
        .older_cnt (older_cnt)
    );

    // Grant bookkeeping: each granted slot corresponds to one valid port
    always_comb begin
        grant_cnt = 0;
        port_cnt  = 0;
        for (int i = 0; i < N; i++) begin
            if (slot_grant[i]) grant_cnt = grant_cnt + 1;
        end
        for (int p = 0; p < ISSUE_WIDTH; p++) begin
            if (issue_valid[p]) port_cnt = port_cnt + 1;
        end
    end

    a_alloc_free: assert property (@(posedge clk) disable iff (reset) (slot_alloc & occ_q) == '0);
    a_grant_cnt:  assert property (@(posedge clk) disable iff (reset) grant_cnt == port_cnt);

endmodule
